// File: rtl/key_debounce_multi_if.sv
// Key pins in, debounced level and event pulses out, one bit per channel.
// Latency: none, this is wiring only.
// Backpressure: none. Pulses are fire-and-forget and the consumer must sample every cycle.
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_rpt;

    // Board/driver side: drives the raw pins and observes the debounced results.
    modport master (
        output key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_rpt
    );

    // Debouncer side.
    modport slave (
        input  key,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_rpt
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: sync, polarity fix, debounced level, press/release/long/repeat pulses.
// Latency: the level and press/release pulses change DEB_CYC+2 edges after a pin change; long comes LONG_CYC after press.
// Backpressure: none. Every output is a registered level or a one-cycle pulse and is never held off.
// Auto-repeat is built only when KEY_DEBOUNCE_REPEAT_EN is defined; otherwise key_rpt is tied to 0.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int RPT_MS      = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  kif
);
    localparam int DEB_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
    localparam int RPT_CYC = CLK_FREQ_HZ / 1000 * RPT_MS;
    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(LONG_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    // Pin level of a released key. The sync flops reset here so that reset never looks like a press.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    // Reject configurations the counters cannot represent.
    if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC || RPT_CYC < 1) begin : g_param_err
        $fatal(1, "key_debounce_multi: bad timing parameters");
    end

    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] long_q;
    logic [N_KEYS-1:0] rpt_q;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          s;
        logic          lvl;
        logic          press_r;
        logic          rel_r;
        logic          long_r;
        logic          long_done;
        logic          fire;
        logic          rel_now;
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= IDLE_LVL;
                sync2 <= IDLE_LVL;
            end else begin
                sync1 <= kif.key[g];
                sync2 <= sync1;
            end
        end

        // s = 1 means pressed, whatever the pin polarity.
        assign s       = sync2 ^ IDLE_LVL;
        // The level flips on this cycle's edge: the sample has disagreed for DEB_CYC samples.
        assign fire    = (s != lvl) && (dcnt == DEB_LAST);
        assign rel_now = fire && !s;

        // Debounce counter, debounced level and the press/release pulses aligned with the level change.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt    <= '0;
                lvl     <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= fire && s;
                rel_r   <= rel_now;
                if (s == lvl) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_LAST) begin
                    lvl  <= s;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end

        // Hold counter: runs while pressed, fires key_long once at LONG_CYC-1, then parks.
        // A release on this edge wins over a long pulse on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hcnt      <= '0;
                long_done <= 1'b0;
                long_r    <= 1'b0;
            end else if (!lvl || rel_now) begin
                hcnt      <= '0;
                long_done <= 1'b0;
                long_r    <= 1'b0;
            end else if (!long_done && hcnt == LONG_LAST) begin
                long_done <= 1'b1;
                long_r    <= 1'b1;
            end else begin
                long_r <= 1'b0;
                if (!long_done) begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end

`ifdef KEY_DEBOUNCE_REPEAT_EN
        localparam int RW = (RPT_CYC > 1) ? $clog2(RPT_CYC) : 1;
        localparam logic [RW-1:0] RPT_LAST = RW'(RPT_CYC - 1);
        logic [RW-1:0] rcnt;
        logic          rpt_r;

        // Repeat counter: starts the cycle after key_long and pulses every RPT_CYC cycles until release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt  <= '0;
                rpt_r <= 1'b0;
            end else if (!lvl || rel_now || !long_done) begin
                rcnt  <= '0;
                rpt_r <= 1'b0;
            end else if (rcnt == RPT_LAST) begin
                rcnt  <= '0;
                rpt_r <= 1'b1;
            end else begin
                rcnt  <= rcnt + RW'(1);
                rpt_r <= 1'b0;
            end
        end

        assign rpt_q[g] = rpt_r;
`else
        assign rpt_q[g] = 1'b0;
`endif

        assign level_q[g]   = lvl;
        assign press_q[g]   = press_r;
        assign release_q[g] = rel_r;
        assign long_q[g]    = long_r;
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.key_rpt     = rpt_q;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: DEB_CYC=4, LONG_CYC=20, RPT_CYC=5, active-low pins.
// Latency: expectations count edges from the first edge that samples a new pin value.
// Backpressure: not applicable; all outputs are compared against hand-derived values on every cycle.
module tb_key_debounce_multi;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [3:0] R0 = 4'b0001;
`else
    localparam logic [3:0] R0 = 4'b0000;
`endif
    localparam logic [3:0] Z = 4'b0000;

    key_debounce_multi_if #(.N_KEYS(4)) kif ();

    key_debounce_multi #(
        .N_KEYS      (4),
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .RPT_MS      (5),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // Compare all five output vectors at once.
    task automatic check(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] lng, input logic [3:0] rpt);
        logic [19:0] obs;
        logic [19:0] req;
        obs = {kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.key_rpt};
        req = {lvl, prs, rel, lng, rpt};
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed lvl/prs/rel/lng/rpt=%h required=%h", tag, obs, req);
        end
    endtask

    // Advance n edges, checking 1 time unit after each one.
    task automatic run(input string tag, input int n, input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel, input logic [3:0] lng, input logic [3:0] rpt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(tag, lvl, prs, rel, lng, rpt);
        end
    endtask

    initial begin
        logic [0:14] bounce;
        bounce = 15'b000100011111111;

        // Reset with all keys held down.
        rst_n   = 1'b0;
        kif.key = 4'b0000;
        #23;
        check("rst_hold", Z, Z, Z, Z, Z);
        run("rst_clocked", 3, Z, Z, Z, Z, Z);
        rst_n = 1'b1;
        run("rst_rel_wait", 5, Z, Z, Z, Z, Z);
        run("rst_rel_press", 1, 4'hF, 4'hF, Z, Z, Z);
        run("rst_rel_held", 1, 4'hF, Z, Z, Z, Z);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_hold", Z, Z, Z, Z, Z);
        kif.key = 4'hF;
        run("rst_idle", 2, Z, Z, Z, Z, Z);
        rst_n = 1'b1;
        run("idle", 10, Z, Z, Z, Z, Z);

        // Clean press on key 0, long press, release 30 cycles after the press.
        kif.key = 4'b1110;
        run("k0_wait", 5, Z, Z, Z, Z, Z);
        run("k0_press", 1, 4'b0001, 4'b0001, Z, Z, Z);
        run("k0_hold", 19, 4'b0001, Z, Z, Z, Z);
        run("k0_long", 1, 4'b0001, Z, Z, 4'b0001, Z);
        run("k0_post_long", 4, 4'b0001, Z, Z, Z, Z);
        run("k0_rpt25", 1, 4'b0001, Z, Z, Z, R0);
        run("k0_gap", 4, 4'b0001, Z, Z, Z, Z);
        run("k0_rpt30", 1, 4'b0001, Z, Z, Z, R0);
        kif.key = 4'b1111;
        run("k0_rel_wait", 4, 4'b0001, Z, Z, Z, Z);
        run("k0_rpt35", 1, 4'b0001, Z, Z, Z, R0);
        run("k0_release", 1, Z, Z, 4'b0001, Z, Z);
        run("k0_idle", 3, Z, Z, Z, Z, Z);

        // Bounce on key 1: runs of 3 pressed samples never reach DEB_CYC.
        for (int i = 0; i < 15; i++) begin
            kif.key[1] = bounce[i];
            @(posedge clk);
            #1;
            check("k1_bounce", Z, Z, Z, Z, Z);
        end

        // Short press on key 2: 12 cycles, no long pulse.
        kif.key = 4'b1011;
        run("k2_wait", 5, Z, Z, Z, Z, Z);
        run("k2_press", 1, 4'b0100, 4'b0100, Z, Z, Z);
        run("k2_hold", 6, 4'b0100, Z, Z, Z, Z);
        kif.key = 4'b1111;
        run("k2_rel_wait", 5, 4'b0100, Z, Z, Z, Z);
        run("k2_release", 1, Z, Z, 4'b0100, Z, Z);
        run("k2_no_long", 25, Z, Z, Z, Z, Z);

        // Keys 3 and 0 together, then asynchronous reset 10 cycles into the hold.
        kif.key = 4'b0110;
        run("k30_wait", 5, Z, Z, Z, Z, Z);
        run("k30_press", 1, 4'b1001, 4'b1001, Z, Z, Z);
        run("k30_hold", 9, 4'b1001, Z, Z, Z, Z);
        #2 rst_n = 1'b0;
        #1 check("k30_async_rst", Z, Z, Z, Z, Z);
        kif.key = 4'b1111;
        run("k30_rst_idle", 2, Z, Z, Z, Z, Z);
        rst_n = 1'b1;
        run("k30_after_rst", 8, Z, Z, Z, Z, Z);

        // Key 0 held 40 cycles past the press: repeat at +25, +30, +35, +40.
        kif.key = 4'b1110;
        run("rp_wait", 5, Z, Z, Z, Z, Z);
        run("rp_press", 1, 4'b0001, 4'b0001, Z, Z, Z);
        run("rp_hold", 19, 4'b0001, Z, Z, Z, Z);
        run("rp_long", 1, 4'b0001, Z, Z, 4'b0001, Z);
        for (int k = 0; k < 4; k++) begin
            run("rp_gap", 4, 4'b0001, Z, Z, Z, Z);
            run("rp_pulse", 1, 4'b0001, Z, Z, Z, R0);
        end
        kif.key = 4'b1111;
        run("rp_rel_wait", 4, 4'b0001, Z, Z, Z, Z);
        run("rp_pulse45", 1, 4'b0001, Z, Z, Z, R0);
        run("rp_release", 1, Z, Z, 4'b0001, Z, Z);
        run("rp_idle", 8, Z, Z, Z, Z, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
